// File: rtl/bp_update_sequencer.sv
// Training-traffic sequencer for the gshare/bimodal predictor: post-reset table sweep,
// round-robin merge of two execute ports, and a small update FIFO. BP_SEQ_STATS_EN adds counters.
module bp_update_sequencer #(
    parameter int PHT_BITS   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          a_valid_i,
    input  logic [31:0]                   a_pc_i,
    input  logic                          a_taken_i,
    output logic                          a_ready_o,
    input  logic                          b_valid_i,
    input  logic [31:0]                   b_pc_i,
    input  logic                          b_taken_i,
    output logic                          b_ready_o,
    input  logic                          flush_i,
    input  logic                          reinit_req_i,
    input  logic                          upd_ready_i,
    output logic                          upd_valid_o,
    output logic [31:0]                   upd_pc_o,
    output logic                          upd_taken_o,
    output logic                          init_valid_o,
    output logic [PHT_BITS-1:0]           init_index_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [31:0]                   stat_updates_o,
    output logic [31:0]                   stat_stalls_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]       DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PHT_BITS-1:0] IDX_LAST = {PHT_BITS{1'b1}};

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [PHT_BITS-1:0] init_idx_q, init_idx_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                rr_q, rr_d;          // 0 = port A has priority, 1 = port B
    logic [32:0]         mem_q [FIFO_DEPTH];

    logic                run_s, full_s, push_s, pop_s, clear_s;
    logic                a_ready_s, b_ready_s;
    logic [31:0]         push_pc_s;
    logic                push_taken_s;

    // Next-state, arbitration and FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rr_d         = rr_q;
        a_ready_s    = 1'b0;
        b_ready_s    = 1'b0;
        pop_s        = 1'b0;
        run_s        = (state_q == ST_RUN);
        full_s       = (count_q == DEPTH_C);

        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + PHT_BITS'(1);
                if (init_idx_q == IDX_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                // Full is judged on the registered count, before any same-cycle pop
                if (!full_s) begin
                    a_ready_s = a_valid_i && (!b_valid_i || !rr_q);
                    b_ready_s = b_valid_i && (!a_valid_i ||  rr_q);
                end else begin
                    a_ready_s = 1'b0;
                    b_ready_s = 1'b0;
                end
                pop_s = (count_q != '0) && upd_ready_i;
                if (reinit_req_i) begin
                    state_d    = ST_INIT;
                    init_idx_d = '0;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_idx_d = '0;
            end
        endcase

        push_s       = a_ready_s || b_ready_s;
        push_pc_s    = b_ready_s ? b_pc_i    : a_pc_i;
        push_taken_s = b_ready_s ? b_taken_i : a_taken_i;
        clear_s      = flush_i || (run_s && reinit_req_i);

        if (push_s) begin
            rr_d = a_ready_s;
        end else begin
            rr_d = rr_q;
        end

        if (clear_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_q       <= rr_d;
        end
    end

    // FIFO storage; a push dropped by flush or reinit is never written
    always_ff @(posedge clk) begin
        if (push_s && !clear_s) begin
            mem_q[wr_ptr_q] <= {push_taken_s, push_pc_s};
        end
    end

    assign a_ready_o    = a_ready_s;
    assign b_ready_o    = b_ready_s;
    assign upd_valid_o  = run_s && (count_q != '0);
    assign upd_pc_o     = mem_q[rd_ptr_q][31:0];
    assign upd_taken_o  = mem_q[rd_ptr_q][32];
    assign init_valid_o = (state_q == ST_INIT);
    assign init_index_o = init_idx_q;
    assign busy_o       = (state_q == ST_INIT);
    assign fifo_count_o = count_q;

`ifdef BP_SEQ_STATS_EN
    logic [31:0] stat_upd_q;
    logic [31:0] stat_stall_q;

    // Delivered-update and port-stall counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_upd_q   <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            if (pop_s && !flush_i) begin
                stat_upd_q <= stat_upd_q + 32'd1;
            end
            if (run_s && ((a_valid_i && !a_ready_s) || (b_valid_i && !b_ready_s))) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_updates_o = stat_upd_q;
    assign stat_stalls_o  = stat_stall_q;
`else
    assign stat_updates_o = 32'd0;
    assign stat_stalls_o  = 32'd0;
`endif

endmodule

// File: tb/tb_bp_update_sequencer.sv
// Directed bench for bp_update_sequencer with PHT_BITS=4, FIFO_DEPTH=4.
module tb_bp_update_sequencer;

    localparam int PB = 4;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_taken, a_ready;
    logic [31:0] a_pc;
    logic        b_valid, b_taken, b_ready;
    logic [31:0] b_pc;
    logic        flush, reinit_req, upd_ready;
    logic        upd_valid, upd_taken, init_valid, busy;
    logic [31:0] upd_pc;
    logic [PB-1:0] init_index;
    logic [2:0]  fifo_count;
    logic [31:0] stat_updates, stat_stalls;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    bp_update_sequencer #(.PHT_BITS(PB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset),
        .a_valid_i(a_valid), .a_pc_i(a_pc), .a_taken_i(a_taken), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_pc_i(b_pc), .b_taken_i(b_taken), .b_ready_o(b_ready),
        .flush_i(flush), .reinit_req_i(reinit_req), .upd_ready_i(upd_ready),
        .upd_valid_o(upd_valid), .upd_pc_o(upd_pc), .upd_taken_o(upd_taken),
        .init_valid_o(init_valid), .init_index_o(init_index), .busy_o(busy),
        .fifo_count_o(fifo_count), .stat_updates_o(stat_updates), .stat_stalls_o(stat_stalls)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected statistic value: counters read as zero when the feature is compiled out
    function automatic logic [31:0] st(input logic [31:0] v);
`ifdef BP_SEQ_STATS_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    // Advance past the next active edge; inputs are then changed and outputs sampled mid-cycle
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; a_valid = 1'b1; a_pc = 32'h0; a_taken = 1'b0;
        b_valid = 1'b1; b_pc = 32'h0; b_taken = 1'b0;
        flush = 1'b0; reinit_req = 1'b0; upd_ready = 1'b1;
        tick;
        #1;
        chk("rst_init_valid", {31'd0, init_valid}, 32'd1);
        chk("rst_init_index", {28'd0, init_index}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd1);
        chk("rst_upd_valid",  {31'd0, upd_valid},  32'd0);
        chk("rst_a_ready",    {31'd0, a_ready},    32'd0);
        chk("rst_b_ready",    {31'd0, b_ready},    32'd0);
        chk("rst_count",      {29'd0, fifo_count}, 32'd0);
        chk("rst_stat_upd",   stat_updates,        32'd0);
        chk("rst_stat_stall", stat_stalls,         32'd0);

        // Sweep: 16 cycles, index 0..15, no readies even with both ports valid
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("sweep_init_valid", {31'd0, init_valid}, 32'd1);
            chk("sweep_index",      {28'd0, init_index}, i);
            chk("sweep_busy",       {31'd0, busy},       32'd1);
            chk("sweep_ready",      {30'd0, a_ready, b_ready}, 32'd0);
            tick;
        end

        // First RUN cycle: rr starts at A; B stalls once. Then A-only streaming.
        for (int k = 0; k < 5; k++) begin
            a_valid = 1'b1; a_pc = 32'h1000 + 32'(4 * k); a_taken = k[0];
            b_valid = (k == 0); b_pc = 32'h2000;
            #1;
            chk("run_busy",    {31'd0, busy},       32'd0);
            chk("run_initv",   {31'd0, init_valid}, 32'd0);
            chk("a_only_rdy",  {31'd0, a_ready},    32'd1);
            chk("a_only_brdy", {31'd0, b_ready},    32'd0);
            if (k == 0) begin
                chk("a_only_cnt0", {29'd0, fifo_count}, 32'd0);
                chk("a_only_uv0",  {31'd0, upd_valid},  32'd0);
            end else begin
                chk("a_only_cnt", {29'd0, fifo_count}, 32'd1);
                chk("a_only_uv",  {31'd0, upd_valid},  32'd1);
                chk("a_only_pc",  upd_pc, 32'h1000 + 32'(4 * (k - 1)));
                chk("a_only_tk",  {31'd0, upd_taken}, 32'((k - 1) & 1));
            end
            tick;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("a_only_last_pc", upd_pc, 32'h1010);
        tick;
        chk("a_only_empty", {29'd0, fifo_count}, 32'd0);

        // One B transfer moves rr back to A, then alternate A,B,A,B
        b_valid = 1'b1; b_pc = 32'h2FC; b_taken = 1'b1;
        #1;
        chk("b_only_rdy", {30'd0, a_ready, b_ready}, 32'd1);
        tick;
        a_pc = 32'h100; a_taken = 1'b1; b_pc = 32'h200; b_taken = 1'b0;
        for (int j = 0; j < 4; j++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            #1;
            chk("rr_a_ready", {31'd0, a_ready}, (j % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_b_ready", {31'd0, b_ready}, (j % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_upd_pc",  upd_pc, (j == 0) ? 32'h2FC : ((j % 2 == 1) ? 32'h100 : 32'h200));
            tick;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("rr_last_pc", upd_pc, 32'h200);
        chk("rr_last_tk", {31'd0, upd_taken}, 32'd0);
        tick;
        chk("rr_empty",      {29'd0, fifo_count}, 32'd0);
        chk("rr_stat_upd",   stat_updates, st(32'd10));
        chk("rr_stat_stall", stat_stalls,  st(32'd5));

        // Fill to full with predictor stalled; the held A request must wait
        upd_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a_valid = 1'b1; a_pc = (k < 4) ? 32'h400 + 32'(4 * k) : 32'h410; a_taken = 1'b0;
            #1;
            chk("full_a_ready", {31'd0, a_ready}, (k < 4) ? 32'd1 : 32'd0);
            chk("full_count",   {29'd0, fifo_count}, (k < 4) ? k : 32'd4);
            if (k > 0) chk("full_head", upd_pc, 32'h400);
            tick;
        end
        upd_ready = 1'b1;
        #1;
        chk("full_pop_noacc", {31'd0, a_ready}, 32'd0);
        chk("full_pop_pc",    upd_pc, 32'h400);
        tick;
        a_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("drain_pc",  upd_pc, 32'h400 + 32'(4 * k));
            chk("drain_cnt", {29'd0, fifo_count}, 32'(4 - k));
            tick;
        end
        chk("drain_empty",      {29'd0, fifo_count}, 32'd0);
        chk("drain_stat_upd",   stat_updates, st(32'd14));
        chk("drain_stat_stall", stat_stalls,  st(32'd8));

        // Flush with 3 buffered and a same-cycle accepted push
        upd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1; a_pc = 32'h500 + 32'(4 * k);
            tick;
        end
        a_pc = 32'h50C; flush = 1'b1; upd_ready = 1'b1;
        #1;
        chk("flush_pre_cnt", {29'd0, fifo_count}, 32'd3);
        chk("flush_a_ready", {31'd0, a_ready},    32'd1);
        chk("flush_upd_v",   {31'd0, upd_valid},  32'd1);
        tick;
        flush = 1'b0; a_valid = 1'b0;
        #1;
        chk("flush_cnt",      {29'd0, fifo_count}, 32'd0);
        chk("flush_upd_v0",   {31'd0, upd_valid},  32'd0);
        chk("flush_stat_upd", stat_updates, st(32'd14));
        a_valid = 1'b1; a_pc = 32'h600;
        tick;
        a_valid = 1'b0;
        #1;
        chk("post_flush_pc",  upd_pc, 32'h600);
        chk("post_flush_cnt", {29'd0, fifo_count}, 32'd1);
        tick;
        chk("post_flush_upd", stat_updates, st(32'd15));

        // Reinit with 2 entries buffered
        upd_ready = 1'b0;
        a_valid = 1'b1; a_pc = 32'h700; tick;
        a_pc = 32'h704; tick;
        a_valid = 1'b0; reinit_req = 1'b1;
        #1;
        chk("reinit_pre_cnt", {29'd0, fifo_count}, 32'd2);
        tick;
        reinit_req = 1'b0; a_valid = 1'b1; b_valid = 1'b1; b_pc = 32'h800;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("reinit_busy",  {31'd0, busy},       32'd1);
            chk("reinit_index", {28'd0, init_index}, i);
            chk("reinit_cnt",   {29'd0, fifo_count}, 32'd0);
            chk("reinit_ready", {30'd0, a_ready, b_ready}, 32'd0);
            tick;
        end
        #1;
        chk("reinit_run_busy", {31'd0, busy}, 32'd0);
        chk("reinit_rr_b",     {30'd0, a_ready, b_ready}, 32'd1);
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("reinit_cnt1",       {29'd0, fifo_count}, 32'd1);
        chk("reinit_head",       upd_pc, 32'h800);
        chk("reinit_stat_stall", stat_stalls,  st(32'd9));
        chk("reinit_stat_upd",   stat_updates, st(32'd15));

        // Reset mid-drain clears everything and restarts the sweep
        reset = 1'b1;
        tick;
        #1;
        chk("rst2_cnt",   {29'd0, fifo_count}, 32'd0);
        chk("rst2_busy",  {31'd0, busy},       32'd1);
        chk("rst2_index", {28'd0, init_index}, 32'd0);
        chk("rst2_stats", stat_updates | stat_stalls, 32'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/bp_update_sequencer.md
# bp_update_sequencer

Sequences training traffic into the hybrid gshare/bimodal branch predictor. After reset it sweeps every table index with an init strobe, so the predictor does not need a single-cycle reset loop. It then accepts resolved-branch outcomes from two execute ports, arbitrates between them round-robin, buffers them in a small FIFO and drains them to the predictor's training port at one update per cycle.

## Interface
- PHT_BITS, 10, predictor table index width; the sweep covers 2^PHT_BITS entries
- FIFO_DEPTH, 4, update buffer entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- a_valid  in  1  port A has a resolved branch
- a_pc  in  32  port A branch PC
- a_taken  in  1  port A actual outcome
- a_ready  out  1  port A transfer accepted this cycle when a_valid
- b_valid, b_pc, b_taken, b_ready  same as port A, for port B
- flush  in  1  discard all buffered updates
- reinit_req  in  1  pulse; restart the table sweep
- upd_ready  in  1  predictor accepts an update
- upd_valid  out  1  FIFO head valid
- upd_pc  out  32  FIFO head PC
- upd_taken  out  1  FIFO head outcome
- init_valid  out  1  clear predictor entry init_index this cycle
- init_index  out  PHT_BITS  entry being cleared (counters → 2'b01, GHR → 0)
- busy  out  1  sweep in progress
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries
- stat_updates  out  32  updates delivered (see Configuration)
- stat_stalls  out  32  port stall cycles (see Configuration)

## Operation
- States:
  - INIT: init_valid=1, init_index increments once per cycle. a_ready=b_ready=0 and upd_valid=0. After the cycle with init_index=2^PHT_BITS−1, go to RUN.
  - RUN: normal traffic. reinit_req=1 goes to INIT with init_index=0 and empties the FIFO. reinit_req is ignored in INIT.
- Arbitration, in RUN only, at most one enqueue per cycle:
  - If the FIFO is full, both readies are 0.
  - With a single valid port, that port gets ready.
  - With both ports valid, the rr pointer picks. The pointer flips to the other port after each accepted transfer.
  - The rr pointer resets to A.
  - A ready may depend combinationally on the valids. A valid without a ready is held by the source.
- Full is evaluated before any same-cycle pop: a push is never accepted when fifo_count=FIFO_DEPTH, even if upd_ready=1.
- Drain: upd_valid = RUN && fifo_count≠0. A pop occurs when upd_valid && upd_ready. FIFO order is acceptance order. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop in RUN (FIFO not full) leaves fifo_count unchanged.
- flush=1:
  - The FIFO is emptied at the next edge.
  - A push accepted in the same cycle is dropped.
  - Readies stay as computed.
  - flush takes priority over the pop; upd_valid is still shown in that cycle, but nothing is counted as delivered.
  - flush during INIT has no effect on the sweep.
- reset mid-sweep or mid-drain: all state returns to reset values and the sweep restarts from index 0.

## Timing
- Reset values, observed after the reset edge: state=INIT, init_valid=1, init_index=0, busy=1, upd_valid=0, a_ready=b_ready=0, fifo_count=0, rr=A, stats=0.
- Sweep length: exactly 2^PHT_BITS cycles with init_valid=1 after reset deasserts. busy falls in the same cycle that RUN begins.
- Earliest acceptance is the first RUN cycle.
- Enqueue-to-upd_valid latency: 1 cycle, with the FIFO registered and the head driven from storage.
- Throughput: 1 update/cycle in and out.
- All outputs except a_ready/b_ready are functions of registered state only.

## Configuration
- BP_SEQ_STATS_EN defined:
  - stat_updates increments on each pop that is not cancelled by flush.
  - stat_stalls increments each RUN cycle in which (a_valid && !a_ready) || (b_valid && !b_ready).
  - Both counters wrap at 2^32 and clear on reset.
- BP_SEQ_STATS_EN undefined: the ports remain and are tied to 0, and no counter logic is generated.

## Test plan
- PHT_BITS=4, release reset → init_valid=1 for exactly 16 cycles with init_index 0..15; busy=0 and a_ready can assert on cycle 17.
- RUN, only A valid each cycle, upd_ready=1 → A accepted every cycle; upd_pc follows with 1-cycle lag; fifo_count stays ≤1.
- A and B continuously valid (A pc=0x100, B pc=0x200), upd_ready=1 → accepted order A,B,A,B; upd_pc sequence 0x100,0x200,…
- upd_ready=0, FIFO_DEPTH=4, A valid for 6 cycles → 4 accepts, then a_ready=0, fifo_count=4. Raise upd_ready with A still valid → no push on the first pop cycle; 4 entries drain in order.
- 3 entries buffered, flush=1 with a_valid=1 → fifo_count=0 next cycle, the A entry is dropped, and stat_updates is unchanged (macro defined).
- reinit_req during drain with 2 entries buffered → next cycle busy=1, init_index=0, fifo_count=0; readies are 0 for 2^PHT_BITS cycles.
